// File: rtl/hazard_unit_bp.sv
`default_nettype none
// ============================================================================
// Module  : hazard_unit_bp
// Brief   : Load-use stall, EX operand forwarding and BHT-based BEQ prediction
//           with flush on mispredict for the 5-stage pipeline.
// Rev     : 1.0  initial release
// ============================================================================
module hazard_unit_bp #(
    parameter int INSTR_W      = 16,
    parameter int OP_W         = 3,
    parameter int REG_AW       = 3,
    parameter int OP_R0        = 0,
    parameter int OP_R1        = 6,
    parameter int OP_BEQ       = 2,
    parameter int OP_LW        = 4,
    parameter int BHT_AW       = 4,
    parameter int PC_W         = 16,
    parameter int CNT_W        = 16,
    parameter int R0_HARDWIRED = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [INSTR_W-1:0]   ifid_instr,
    input  logic [PC_W-1:0]      ifid_pc,
    input  logic [INSTR_W-1:0]   idex_instr,
    input  logic                 idex_write,
    input  logic                 idex_regdst,
    input  logic                 idex_memread,
    input  logic [INSTR_W-1:0]   exmem_instr,
    input  logic                 exmem_write,
    input  logic                 exmem_regdst,
    input  logic                 memwb_write,
    input  logic [REG_AW-1:0]    memwb_wreg,
    input  logic                 br_resolve,
    input  logic                 br_taken,
    output logic                 pc_stall,
    output logic                 ifid_stall,
    output logic                 idex_bubble,
    output logic                 flush,
    output logic                 mispredict,
    output logic                 predict_taken,
    output logic [1:0]           fwd_a,
    output logic [1:0]           fwd_b,
    output logic [CNT_W-1:0]     stall_count,
    output logic [CNT_W-1:0]     mispredict_count
);

    localparam int               c_RS_MSB    = INSTR_W - OP_W - 1;
    localparam int               c_RT_MSB    = c_RS_MSB - REG_AW;
    localparam int               c_RD_MSB    = c_RT_MSB - REG_AW;
    localparam int               c_BHT_DEPTH = 2 ** BHT_AW;
    localparam logic [CNT_W-1:0] c_CNT_MAX   = '1;

    logic [OP_W-1:0]   w_id_op;
    logic [REG_AW-1:0] w_id_rs;
    logic [REG_AW-1:0] w_id_rt;
    logic [REG_AW-1:0] w_ex_dest;
    logic [REG_AW-1:0] w_mem_dest;
    logic [BHT_AW-1:0] w_id_idx;
    logic              w_id_beq;
    logic              w_id_uses_rt;
    logic              w_ex_dest_nz;
    logic              w_load_use;
    logic              w_mispredict;
    logic              w_stall;
    logic              w_pred;
    logic [REG_AW-1:0] w_ex_src [2];
    logic [1:0]        w_fwd    [2];
    logic              w_unused;

    logic [1:0]        r_bht [c_BHT_DEPTH];
    logic              r_idp_valid;
    logic              r_idp_pred;
    logic [BHT_AW-1:0] r_idp_idx;
    logic              r_exp_valid;
    logic              r_exp_pred;
    logic [BHT_AW-1:0] r_exp_idx;
    logic [CNT_W-1:0]  r_stall_count;
    logic [CNT_W-1:0]  r_mispredict_count;

    assign w_id_op      = ifid_instr[INSTR_W-1 -: OP_W];
    assign w_id_rs      = ifid_instr[c_RS_MSB -: REG_AW];
    assign w_id_rt      = ifid_instr[c_RT_MSB -: REG_AW];
    assign w_id_idx     = ifid_pc[BHT_AW-1:0];
    assign w_id_beq     = (w_id_op == OP_W'(OP_BEQ));
    assign w_id_uses_rt = w_id_beq || (w_id_op == OP_W'(OP_R0)) || (w_id_op == OP_W'(OP_R1));

    assign w_ex_dest    = idex_regdst  ? idex_instr[c_RD_MSB -: REG_AW]  : idex_instr[c_RT_MSB -: REG_AW];
    assign w_mem_dest   = exmem_regdst ? exmem_instr[c_RD_MSB -: REG_AW] : exmem_instr[c_RT_MSB -: REG_AW];
    assign w_ex_dest_nz = (R0_HARDWIRED == 0) || (w_ex_dest != '0);

    assign w_load_use = reset && idex_memread && idex_write && w_ex_dest_nz &&
                        ((w_ex_dest == w_id_rs) || (w_id_uses_rt && (w_ex_dest == w_id_rt)));

    // An unpredicted branch (no pending entry) was implicitly predicted not-taken.
    assign w_mispredict = reset && br_resolve &&
                          (r_exp_valid ? (br_taken != r_exp_pred) : br_taken);

    // Flush beats the load-use stall: the stalled instruction is being killed anyway.
    assign w_stall = w_load_use && !w_mispredict;
    assign w_pred  = reset && w_id_beq && r_bht[w_id_idx][1];

    assign w_ex_src[0] = idex_instr[c_RS_MSB -: REG_AW];
    assign w_ex_src[1] = idex_instr[c_RT_MSB -: REG_AW];

    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
        logic w_src_nz;
        assign w_src_nz  = (R0_HARDWIRED == 0) || (w_ex_src[gi] != '0);
        assign w_fwd[gi] = (!reset || !w_src_nz)                            ? 2'd0 :
                           (exmem_write && (w_mem_dest == w_ex_src[gi]))    ? 2'd1 :
                           (memwb_write && (memwb_wreg == w_ex_src[gi]))    ? 2'd2 : 2'd0;
    end

    assign pc_stall         = !reset || w_stall;
    assign ifid_stall       = w_stall;
    assign idex_bubble      = w_stall;
    assign flush            = w_mispredict;
    assign mispredict       = w_mispredict;
    assign predict_taken    = w_pred;
    assign fwd_a            = w_fwd[0];
    assign fwd_b            = w_fwd[1];
    assign stall_count      = r_stall_count;
    assign mispredict_count = r_mispredict_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < c_BHT_DEPTH; i++) begin
                r_bht[i] <= 2'b01;
            end
        end else if (br_resolve && r_exp_valid) begin
            if (br_taken && (r_bht[r_exp_idx] != 2'b11)) begin
                r_bht[r_exp_idx] <= r_bht[r_exp_idx] + 2'd1;
            end else if (!br_taken && (r_bht[r_exp_idx] != 2'b00)) begin
                r_bht[r_exp_idx] <= r_bht[r_exp_idx] - 2'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_idp_valid <= 1'b0;
            r_idp_pred  <= 1'b0;
            r_idp_idx   <= '0;
            r_exp_valid <= 1'b0;
            r_exp_pred  <= 1'b0;
            r_exp_idx   <= '0;
        end else if (w_mispredict) begin
            r_idp_valid <= 1'b0;
            r_idp_pred  <= 1'b0;
            r_idp_idx   <= '0;
            r_exp_valid <= 1'b0;
            r_exp_pred  <= 1'b0;
            r_exp_idx   <= '0;
        end else if (w_stall) begin
            r_exp_valid <= 1'b0;
            r_exp_pred  <= 1'b0;
            r_exp_idx   <= '0;
        end else begin
            r_exp_valid <= r_idp_valid;
            r_exp_pred  <= r_idp_pred;
            r_exp_idx   <= r_idp_idx;
            r_idp_valid <= w_id_beq;
            r_idp_pred  <= w_pred;
            r_idp_idx   <= w_id_beq ? w_id_idx : '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_stall_count      <= '0;
            r_mispredict_count <= '0;
        end else begin
            if (w_stall && (r_stall_count != c_CNT_MAX)) begin
                r_stall_count <= r_stall_count + CNT_W'(1);
            end
            if (w_mispredict && (r_mispredict_count != c_CNT_MAX)) begin
                r_mispredict_count <= r_mispredict_count + CNT_W'(1);
            end
        end
    end

    // Loads are recognised by idex_memread, so the load opcode itself is never decoded.
    assign w_unused = ^{ifid_pc[PC_W-1:BHT_AW], ifid_instr[c_RD_MSB:0],
                        idex_instr[INSTR_W-1 -: OP_W], idex_instr[c_RD_MSB-REG_AW:0],
                        exmem_instr[INSTR_W-1:c_RT_MSB+1], exmem_instr[c_RD_MSB-REG_AW:0],
                        OP_W'(OP_LW)};

endmodule
`default_nettype wire

// File: doc/hazard_unit_bp.md
Name: hazard_unit_bp

Overview:
- Parametrised successor hazard controller for the 5-stage pipeline.
- Detects load-use hazards and generates stall/bubble controls.
- Generates EX-stage operand forwarding selects.
- Predicts BEQ direction with an indexed table of 2-bit saturating counters, and raises flush on misprediction; keeps stall and mispredict statistics.

Parameters:
INSTR_W, 16, instruction width
OP_W, 3, opcode width; opcode = instr[INSTR_W-1 -: OP_W]
REG_AW, 3, register address width; rs, rt, rd fields follow the opcode contiguously, MSB first (16-bit: 12:10, 9:7, 6:4)
OP_R0, 0, first R-type opcode
OP_R1, 6, second R-type opcode
OP_BEQ, 2, branch opcode
OP_LW, 4, load opcode
BHT_AW, 4, predictor index bits; table depth 2**BHT_AW
PC_W, 16, PC width
CNT_W, 16, statistics counter width
R0_HARDWIRED, 1, when 1, register 0 never creates a hazard or forward

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
ifid_instr  in  INSTR_W  instruction in ID
ifid_pc  in  PC_W  PC of ifid_instr; BHT index = ifid_pc[BHT_AW-1:0]
idex_instr  in  INSTR_W  instruction in EX
idex_write  in  1  EX instruction writes a register
idex_regdst  in  1  0: dest = rt, 1: dest = rd
idex_memread  in  1  EX instruction is a load
exmem_instr  in  INSTR_W  instruction in MEM
exmem_write  in  1  MEM instruction writes a register
exmem_regdst  in  1  as idex_regdst
memwb_write  in  1  WB instruction writes a register
memwb_wreg  in  REG_AW  WB destination register
br_resolve  in  1  branch in EX resolved this cycle
br_taken  in  1  actual outcome, valid with br_resolve
pc_stall  out  1  hold PC
ifid_stall  out  1  hold IF/ID register
idex_bubble  out  1  load NOP into ID/EX
flush  out  1  kill IF/ID and ID/EX contents
mispredict  out  1  misprediction this cycle
predict_taken  out  1  prediction for the BEQ in ID
fwd_a  out  2  EX rs source: 0 regfile, 1 EX/MEM, 2 MEM/WB
fwd_b  out  2  EX rt source, same encoding
stall_count  out  CNT_W  saturating count of stall cycles
mispredict_count  out  CNT_W  saturating count of mispredicts

Behaviour:
- Reset (reset=0, asynchronous):
  - All BHT entries set to 2'b01 (weakly not-taken).
  - Pending-branch registers cleared; both counters set to 0.
  - pc_stall=1 while reset is low; all other outputs 0.
- Destination registers: EX dest = idex_regdst ? rd : rt, taken from idex_instr; MEM dest from exmem_instr by the same rule.
- Sources used by the ID instruction: R-type (OP_R0/OP_R1) uses rs and rt; BEQ uses rs and rt; all other opcodes use rs only.
- Load-use hazard (combinational): idex_memread & idex_write & EX dest equals any ID source, and the dest is non-zero when R0_HARDWIRED.
  - Asserts pc_stall=ifid_stall=idex_bubble=1 for exactly one cycle.
  - No stall for non-load EX writers; forwarding covers those.
- Forwarding (combinational, from idex_instr rs and rt):
  - EX/MEM match (exmem_write) has priority over MEM/WB match (memwb_write).
  - No forward for register 0 when R0_HARDWIRED.
- Prediction:
  - predict_taken = BHT[idx][1] when the ID opcode is OP_BEQ, else 0.
  - On a clock edge with a BEQ in ID and no stall or flush, capture {valid, pred, idx} into the ID-pending register.
  - The ID-pending register shifts to the EX-pending register each non-stall edge; on a stall, a cleared entry shifts in.
- Resolution:
  - mispredict = br_resolve & (br_taken != ex_pred); flush = mispredict (combinational).
  - br_resolve with the EX-pending entry invalid: mispredict = br_taken, no BHT update.
  - At the edge with a valid br_resolve, BHT[ex_idx] saturates up on taken and down on not-taken (3 and 0 saturate).
- Simultaneous load-use stall and mispredict:
  - Flush wins: pc_stall=ifid_stall=idex_bubble=0, and the stall is not counted.
  - Both pending registers are cleared.
- Counters:
  - stall_count increments each cycle pc_stall is due to a hazard.
  - mispredict_count increments each mispredict cycle.
  - Both hold at all-ones.
- Reset mid-operation: asynchronous clear of all state; the first post-reset cycle behaves as a fresh start.

Test Plan:
- Reset low for 3 cycles, then release → pc_stall=1 during reset; all BHT entries read 01; predict_taken=0 for a BEQ at any PC; counters 0.
- LW r2 in EX (idex_memread=1, write=1, regdst=0), ADD r3,r2,r1 in ID → exactly one cycle of pc_stall=ifid_stall=idex_bubble=1; stall_count=1.
- exmem dest r5 and memwb_wreg r5, EX rs=r5 → fwd_a=1; with exmem_write=0 → fwd_a=2; dest r0 with R0_HARDWIRED=1 → fwd_a=0.
- BEQ at PC 0x0013 resolves taken twice → first resolve: mispredict=flush=1, BHT[3]=10; next BEQ at the same PC gives predict_taken=1 and no mispredict on taken.
- Load-use stall and mispredict in the same cycle → flush=1, pc_stall=0, stall_count unchanged, mispredict_count +1.
- Force mispredict_count to all-ones with CNT_W=4 (16 mispredicts) → count holds at 15.
